// File: rtl/led_blink_mon.sv
// LED blink monitor: synchronizes an LED from the reconfigurable partition and
// measures its toggle half-period, floor-log2 rate code, toggle count and stuck state.
module led_blink_mon #(
   parameter int unsigned CNT_W   = 32,
   parameter int unsigned TIMEOUT = 200_000_000
) (
   input  logic             clk100,
   input  logic             rstn,
   input  logic             led_i,
   input  logic             clr_i,
   output logic [CNT_W-1:0] half_per_o,
   output logic [5:0]       log2_o,
   output logic             per_vld_o,
   output logic [15:0]      toggles_o,
   output logic             stuck_o,
   output logic             led_lvl_o
);

   localparam logic [CNT_W-1:0] CNT_MAX   = '1;
   localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      MEAS  = 2'b01,
      STUCK = 2'b10
   } state_e;

   state_e           state_q, state_d;
   logic             s1_q, s1_d;
   logic             s2_q, s2_d;
   logic             dly_q, dly_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] half_per_q, half_per_d;
   logic [5:0]       log2_q, log2_d;
   logic             per_vld_q, per_vld_d;
   logic [15:0]      toggles_q, toggles_d;
   logic             stuck_q, stuck_d;
   logic             led_edge;

   // Priority encoder: index of the highest set bit, 0 for a zero input.
   function automatic logic [5:0] floor_log2(input logic [CNT_W-1:0] v);
      logic [5:0] r;
      r = '0;
      for (int i = 0; i < CNT_W; i++) begin
         if (v[i]) r = 6'(i);
      end
      return r;
   endfunction

   assign led_edge = s2_q ^ dly_q;

   always_comb begin
      s1_d       = led_i;
      s2_d       = s1_q;
      dly_d      = s2_q;
      state_d    = state_q;
      cnt_d      = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
      half_per_d = half_per_q;
      log2_d     = log2_q;
      per_vld_d  = 1'b0;
      toggles_d  = toggles_q;
      stuck_d    = stuck_q;

      if (clr_i) begin
         // Clear also swallows any edge seen this cycle.
         state_d    = IDLE;
         cnt_d      = '0;
         half_per_d = '0;
         log2_d     = '0;
         toggles_d  = '0;
         stuck_d    = 1'b0;
      end else if (led_edge) begin
         toggles_d = toggles_q + 16'd1;
         cnt_d     = CNT_W'(1);
         stuck_d   = 1'b0;
         state_d   = MEAS;
         // Only an armed, non-stuck measurement has a valid interval to capture.
         if (state_q == MEAS) begin
            half_per_d = cnt_q;
            log2_d     = floor_log2(cnt_q);
            per_vld_d  = 1'b1;
         end
      end else begin
         case (state_q)
            IDLE, MEAS: begin
               if (cnt_q == TIMEOUT_C) begin
                  state_d = STUCK;
                  stuck_d = 1'b1;
               end
            end
            STUCK:   stuck_d = 1'b1;
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk100) begin
      if (!rstn) begin
         state_q    <= IDLE;
         s1_q       <= 1'b0;
         s2_q       <= 1'b0;
         dly_q      <= 1'b0;
         cnt_q      <= '0;
         half_per_q <= '0;
         log2_q     <= '0;
         per_vld_q  <= 1'b0;
         toggles_q  <= '0;
         stuck_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         s1_q       <= s1_d;
         s2_q       <= s2_d;
         dly_q      <= dly_d;
         cnt_q      <= cnt_d;
         half_per_q <= half_per_d;
         log2_q     <= log2_d;
         per_vld_q  <= per_vld_d;
         toggles_q  <= toggles_d;
         stuck_q    <= stuck_d;
      end
   end

   assign half_per_o = half_per_q;
   assign log2_o     = log2_q;
   assign per_vld_o  = per_vld_q;
   assign toggles_o  = toggles_q;
   assign stuck_o    = stuck_q;
   assign led_lvl_o  = s2_q;

endmodule

// File: tb/tb_led_blink_mon.sv
// Bench for led_blink_mon: directed phases plus random LED waveforms, every cycle
// compared against a timestamp-based reference model.
module tb_led_blink_mon;

   localparam int unsigned CNT_W   = 16;
   localparam int unsigned TIMEOUT = 100;

   logic             clk100 = 1'b0;
   logic             rstn   = 1'b0;
   logic             led_i  = 1'b0;
   logic             clr_i  = 1'b0;
   logic [CNT_W-1:0] half_per_o;
   logic [5:0]       log2_o;
   logic             per_vld_o;
   logic [15:0]      toggles_o;
   logic             stuck_o;
   logic             led_lvl_o;

   led_blink_mon #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
      .clk100     (clk100),
      .rstn       (rstn),
      .led_i      (led_i),
      .clr_i      (clr_i),
      .half_per_o (half_per_o),
      .log2_o     (log2_o),
      .per_vld_o  (per_vld_o),
      .toggles_o  (toggles_o),
      .stuck_o    (stuck_o),
      .led_lvl_o  (led_lvl_o)
   );

   always #5 clk100 = ~clk100;

   int unsigned n_vec = 0;
   int unsigned n_err = 0;

   // Reference model state: time of the last edge (or virtual load after clear)
   longint   cyc   = 0;
   longint   t_ref = 1;
   bit       armed = 1'b0;
   bit [2:0] hv    = 3'b000;   // hv[0] newest sampled LED value
   longint   m_half = 0;
   longint   m_tog  = 0;
   bit       m_vld  = 1'b0;
   bit       m_stuck = 1'b0;
   logic     led_cur = 1'b0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic longint ref_log2(input longint v);
      return (v == 0) ? 0 : longint'($clog2(v + 1)) - 1;
   endfunction

   task automatic step(input logic led, input logic clr, input logic rn);
      bit edge_m;
      @(negedge clk100);
      led_i = led;
      clr_i = clr;
      rstn  = rn;
      @(posedge clk100);
      cyc++;
      edge_m = hv[1] ^ hv[2];
      hv     = rn ? {hv[1:0], led} : 3'b000;
      if (!rn || clr) begin
         armed   = 1'b0;
         t_ref   = cyc + 1;
         m_tog   = 0;
         m_half  = 0;
         m_vld   = 1'b0;
         m_stuck = 1'b0;
      end else if (edge_m) begin
         m_tog = (m_tog + 1) % 65536;
         m_vld = 1'b0;
         if (armed && (cyc - t_ref) <= longint'(TIMEOUT)) begin
            m_half = cyc - t_ref;
            m_vld  = 1'b1;
         end
         armed   = 1'b1;
         t_ref   = cyc;
         m_stuck = 1'b0;
      end else begin
         m_vld   = 1'b0;
         m_stuck = (cyc - t_ref) >= longint'(TIMEOUT);
      end
      #1;
      chk("half_per", 64'(half_per_o), 64'(m_half));
      chk("log2",     64'(log2_o),     64'(ref_log2(m_half)));
      chk("per_vld",  64'(per_vld_o),  64'(m_vld));
      chk("toggles",  64'(toggles_o),  64'(m_tog));
      chk("stuck",    64'(stuck_o),    64'(m_stuck));
      chk("led_lvl",  64'(led_lvl_o),  64'(hv[1]));
   endtask

   task automatic square(input int half, input int n_edges);
      for (int e = 0; e < n_edges; e++) begin
         led_cur = ~led_cur;
         for (int i = 0; i < half; i++) step(led_cur, 1'b0, 1'b1);
      end
   endtask

   initial begin
      // Reset held while the LED toggles
      for (int i = 0; i < 4; i++) begin
         led_cur = ~led_cur;
         step(led_cur, 1'b0, 1'b0);
      end
      chk("rst_half",    64'(half_per_o), 64'd0);
      chk("rst_toggles", 64'(toggles_o),  64'd0);
      chk("rst_stuck",   64'(stuck_o),    64'd0);
      chk("rst_vld",     64'(per_vld_o),  64'd0);
      led_cur = 1'b0;

      square(50, 6);
      chk("sq50_half", 64'(half_per_o), 64'd50);
      chk("sq50_log2", 64'(log2_o),     64'd5);

      square(7, 8);
      chk("sq7_half", 64'(half_per_o), 64'd7);
      chk("sq7_log2", 64'(log2_o),     64'd2);

      // One edge then hold long enough to go stuck
      led_cur = ~led_cur;
      for (int i = 0; i < 115; i++) step(led_cur, 1'b0, 1'b1);
      chk("stuck_set", 64'(stuck_o), 64'd1);
      square(30, 1);
      chk("stuck_clr", 64'(stuck_o), 64'd0);
      chk("stuck_nocap", 64'(half_per_o), 64'd7);
      square(30, 1);
      chk("post_stuck_half", 64'(half_per_o), 64'd30);

      // Clear coincides with the detected edge
      led_cur = ~led_cur;
      step(led_cur, 1'b0, 1'b1);
      step(led_cur, 1'b0, 1'b1);
      step(led_cur, 1'b1, 1'b1);
      chk("clr_toggles", 64'(toggles_o),  64'd0);
      chk("clr_half",    64'(half_per_o), 64'd0);
      chk("clr_stuck",   64'(stuck_o),    64'd0);
      square(20, 3);
      chk("clr_rearm_tog",  64'(toggles_o),  64'd3);
      chk("clr_rearm_half", 64'(half_per_o), 64'd20);

      // Random waveforms with occasional clear and reset
      for (int s = 0; s < 150; s++) begin
         int unsigned half;
         half    = $urandom_range(1, 130);
         led_cur = ~led_cur;
         for (int unsigned i = 0; i < half; i++) begin
            step(led_cur, ($urandom_range(0, 199) == 0), ($urandom_range(0, 499) != 0));
         end
      end

      // Toggle every cycle long enough to wrap the toggle counter
      for (int i = 0; i < 3; i++) step(led_cur, 1'b0, 1'b1);
      step(led_cur, 1'b1, 1'b1);
      for (int i = 0; i < 65545; i++) begin
         led_cur = ~led_cur;
         step(led_cur, 1'b0, 1'b1);
      end
      chk("fast_half",    64'(half_per_o), 64'd1);
      chk("fast_log2",    64'(log2_o),     64'd0);
      chk("fast_vld",     64'(per_vld_o),  64'd1);
      chk("fast_toggles", 64'(toggles_o),  64'd7);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/led_blink_mon.md
# led_blink_mon

LED blink monitor that observes the `led_o` output of the reconfigurable LED counter partition and measures it. It reports the half-period between toggles in `clk100` cycles, a floor-log2 rate code, a toggle count, and a stuck flag. It sits in the static region beside the reconfigurable-partition wrapper. Software or ILA reads its outputs to confirm which LED counter variant is loaded and at what divide rate it runs.

## Interface
Parameters:
- `CNT_W`, default 32: width of the interval counter and `half_per_o`.
- `TIMEOUT`, default 200_000_000: cycles without an edge before `stuck_o` asserts (2 s at 100 MHz). Must satisfy 1 < `TIMEOUT` < 2^`CNT_W`.

Ports:
- `clk100`, in, 1: system clock, 100 MHz. Single clock domain.
- `rstn`, in, 1: reset, synchronous, active-low.
- `led_i`, in, 1: LED signal from the partition. Passed through a 2-flop synchronizer.
- `clr_i`, in, 1: synchronous clear of measurement state. Level-sensitive, acts every cycle it is high.
- `half_per_o`, out, `CNT_W`: last measured interval between consecutive toggles, in cycles.
- `log2_o`, out, 6: floor(log2(`half_per_o`)). 0 when `half_per_o` is 0.
- `per_vld_o`, out, 1: one-cycle pulse when `half_per_o`/`log2_o` update.
- `toggles_o`, out, 16: count of detected edges. Wraps at 0xFFFF.
- `stuck_o`, out, 1: no edge for `TIMEOUT` cycles.
- `led_lvl_o`, out, 1: synchronized LED level (second synchronizer stage).

## Operation
- Synchronizer: `s1 <= led_i`, `s2 <= s1`, `d <= s2`. `edge = s2 ^ d`. `led_lvl_o = s2`.
- Interval counter `cnt`, `CNT_W` bits:
  - Increments every cycle and saturates at all-ones.
  - Loads 1 on an edge.
  - Loads 0 on reset or clear.
- State machine, 2-bit encoding:
  - IDLE (reset state), not armed:
    - edge -> MEAS, `cnt <= 1`, no capture.
    - `cnt == TIMEOUT` with no edge -> STUCK.
  - MEAS:
    - edge -> capture: `half_per_o <= cnt`, `log2_o <= floor(log2(cnt))`, `per_vld_o` pulses, `cnt <= 1`. Stay in MEAS.
    - `cnt == TIMEOUT` with no edge -> STUCK.
  - STUCK:
    - `stuck_o = 1`.
    - edge -> MEAS, `cnt <= 1`, `stuck_o <= 0`, no capture, because the interval is invalid.
- `toggles_o` increments on every edge in every state.
- `log2_o` is computed from `cnt` by a priority encoder and registered in the same clock as `half_per_o`. The two never disagree.
- Priority, highest first: `rstn` low, then `clr_i`, then edge, then timeout.
  - Reset/clear: IDLE; `cnt`, `half_per_o`, `log2_o`, `toggles_o`, `per_vld_o`, `stuck_o` all 0.
  - Synchronizer flops reset on `rstn` only, not on `clr_i`.
- An edge and `cnt == TIMEOUT` in the same cycle: edge wins, no stuck.
- An edge arriving while `clr_i` is high is discarded entirely: no toggle count, no arming.
- Reset mid-measurement discards the partial interval. The first post-reset edge only arms, even if caused by `led_i` being high at reset release.

## Timing
- Reset value of every output: 0.
- Latency: `led_i` change sampled at rising edge k -> `s2` at k+1 -> `per_vld_o`, `half_per_o`, `log2_o`, `toggles_o` updated at edge k+2.
- `per_vld_o` is high exactly one cycle per capture.
- `half_per_o` holds between captures.
- Captured value equals the number of clock cycles between the two sampled toggles.
  - Minimum 1: toggle every cycle.
  - Saturates at 2^`CNT_W`-1; unreachable in practice because STUCK intervenes first.
- `stuck_o` rises on the edge where `cnt` reaches `TIMEOUT`, i.e. `TIMEOUT` cycles after the last edge's `cnt <= 1` load.
  - In IDLE after reset, `stuck_o` rises `TIMEOUT`+1 cycles after reset release, because `cnt` starts at 0.

## Test plan
- Reset: hold `rstn` low 4 cycles while toggling `led_i` -> all outputs 0, no `per_vld_o`, state IDLE.
- Square wave, half-period 50: first edge -> `toggles_o`=1, no `per_vld_o`; second edge -> `half_per_o`=50, `log2_o`=5, one-cycle `per_vld_o` 3 clocks after the `led_i` change; steady state repeats 50.
- Period change 50 -> 7 mid-stream: subsequent captures 7, `log2_o`=2; no spurious `per_vld_o`.
- `TIMEOUT`=100, hold `led_i` after an edge -> `stuck_o`=1 exactly 100 cycles later; next edge clears `stuck_o` without `per_vld_o`; the edge after that captures normally.
- `clr_i` asserted in the same cycle as a detected edge -> `toggles_o`=0, `half_per_o`=0, `stuck_o`=0; the next edge only arms.
- Toggle `led_i` every cycle for 65 540 edges -> `half_per_o`=1, `log2_o`=0, `per_vld_o` high continuously after arming; `toggles_o` wraps 0xFFFF -> 0x0000.
